pipe_stage_reg: RTL and testbench

- Parametrised, handshaked pipeline-stage register: generic successor to the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque data payload and a control bundle with a per-entry valid bit, a one-entry skid buffer, flush and bubble insertion.
- Instantiated between every pair of datapath stages; hazard unit drives flush, downstream stage drives out_ready.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_perf_cnt.sv | 25 ++
 rtl/pipe_stage_reg.sv | 140 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the handshaked pipeline-stage register.
// Optional feature macro: PIPE_PERF_EN (performance counters in pipe_stage_reg).
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam int PIPE_DATA_W = 122;
  localparam int PIPE_CTRL_W = 17;
  localparam int PIPE_CNT_W  = 32;

  // All-zero control decodes downstream as a NOP: no regwrite, no memory op.
  localparam logic [PIPE_CTRL_W-1:0] BUBBLE_CTRL = '0;

  function automatic logic state_has_main(input pipe_state_t st);
    return (st == HALF) || (st == FULL);
  endfunction

  function automatic logic state_has_skid(input pipe_state_t st);
    return (st == FULL);
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter with enable; present only when PIPE_PERF_EN is defined.
`ifdef PIPE_PERF_EN
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (en && !(&cnt_reg)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline-stage register with one-entry skid buffer, flush and bubble control.
// Optional feature macro: PIPE_PERF_EN adds saturating stall/bubble counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
`ifdef PIPE_PERF_EN
  ,
  parameter int CNT_W  = PIPE_CNT_W
`endif
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  pipe_state_t state_reg, state_next;

  logic              m_valid, s_valid;
  logic              accept, consume;
  logic              load_main_in, load_main_skid, load_skid_in;
  logic [DATA_W-1:0] m_data_reg, s_data_reg;
  logic [CTRL_W-1:0] m_ctrl_reg, s_ctrl_reg;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; flush overrides everything, a same-cycle consume still completes.
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: if (accept) state_next = HALF;
        HALF: begin
          if (accept && !consume)      state_next = FULL;
          else if (!accept && consume) state_next = EMPTY;
        end
        FULL:  if (consume) state_next = HALF;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Output / load-select logic, all derived from registered state (no out_ready -> in_ready path).
  always_comb begin
    m_valid        = state_has_main(state_reg);
    s_valid        = state_has_skid(state_reg);
    accept         = in_valid && !s_valid;
    consume        = m_valid && out_ready;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (!flush) begin
      case (state_reg)
        EMPTY:   load_main_in = accept;
        HALF: begin
          load_main_in = accept && consume;
          load_skid_in = accept && !consume;
        end
        FULL:    load_main_skid = consume;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_data_reg <= '0;
      m_ctrl_reg <= '0;
      s_data_reg <= '0;
      s_ctrl_reg <= '0;
    end else begin
      if (load_main_in) begin
        m_data_reg <= in_data;
        m_ctrl_reg <= in_ctrl;
      end else if (load_main_skid) begin
        m_data_reg <= s_data_reg;
        m_ctrl_reg <= s_ctrl_reg;
      end
      if (load_skid_in) begin
        s_data_reg <= in_data;
        s_ctrl_reg <= in_ctrl;
      end
    end
  end

  assign in_ready  = !s_valid;
  assign out_valid = m_valid;
  assign out_data  = m_data_reg;
  // Stale control must never leak out while the head is empty.
  assign out_ctrl  = m_valid ? m_ctrl_reg : CTRL_W'(BUBBLE_CTRL);

`ifdef PIPE_PERF_EN
  logic [1:0]       perf_en;
  logic [CNT_W-1:0] perf_cnt [2];

  assign perf_en[0] = m_valid && !out_ready;
  assign perf_en[1] = !m_valid;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_perf
      pipe_perf_cnt #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk   (CLK),
        .rst_n (nRST),
        .en    (perf_en[gi]),
        .cnt   (perf_cnt[gi])
      );
    end
  endgenerate

  assign stall_cnt  = perf_cnt[0];
  assign bubble_cnt = perf_cnt[1];
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; counter checks compiled only with PIPE_PERF_EN.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = PIPE_DATA_W;
  localparam int CW = PIPE_CTRL_W;
`ifdef PIPE_PERF_EN
  localparam int TCW = 3;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
`ifdef PIPE_PERF_EN
  logic [TCW-1:0] stall_cnt;
  logic [TCW-1:0] bubble_cnt;
`endif

  int   n_checks = 0;
  int   n_err    = 0;
  ent_t sb_q[$];

  pipe_stage_reg #(
    .DATA_W (DW),
    .CTRL_W (CW)
`ifdef PIPE_PERF_EN
    ,
    .CNT_W  (TCW)
`endif
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl)
`ifdef PIPE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: consume first (head was accepted in an earlier cycle), then record new accepts.
  always @(negedge CLK) begin
    ent_t e;
    if (!nRST) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_out: got data %0h ctrl %0h, expected no entry", out_data, out_ctrl);
        end else begin
          e = sb_q.pop_front();
          check("out_data", 128'(out_data), 128'(e.d));
          check("out_ctrl", 128'(out_ctrl), 128'(e.c));
          $display("pop  data=%0h ctrl=%0h", out_data, out_ctrl);
        end
      end
      if (!out_valid) check("bubble_ctrl", 128'(out_ctrl), 128'h0);
      if (flush) begin
        sb_q.delete();
      end else if (in_valid && in_ready) begin
        e = {in_data, in_ctrl};
        sb_q.push_back(e);
        $display("push data=%0h ctrl=%0h", in_data, in_ctrl);
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0);
    cyc(); cyc();
    // Reset state
    check("rst_out_valid", 128'(out_valid), 128'h0);
    check("rst_out_ctrl",  128'(out_ctrl),  128'h0);
    check("rst_out_data",  128'(out_data),  128'h0);
    check("rst_in_ready",  128'(in_ready),  128'h1);
    nRST = 1'b1;

    // 1: single entry, one-cycle latency
    drive(1'b1, DW'(8'hA5), CW'(8'h1F));
    out_ready = 1'b1;
    cyc();
    drive(1'b0, '0, '0);
    check("t1_out_valid", 128'(out_valid), 128'h1);
    check("t1_out_data",  128'(out_data),  128'hA5);
    check("t1_out_ctrl",  128'(out_ctrl),  128'h1F);
    cyc();

    // 2: full-rate stream
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), CW'(i));
      cyc();
      check("t2_in_ready", 128'(in_ready), 128'h1);
    end
    drive(1'b0, '0, '0);
    cyc(); cyc();
    check("t2_drained", 128'(sb_q.size()), 128'h0);

    // 3: backpressure fills main then skid
    out_ready = 1'b0;
    drive(1'b1, DW'(8'h11), CW'(1));
    cyc();
    check("t3_in_ready_half", 128'(in_ready), 128'h1);
    drive(1'b1, DW'(8'h22), CW'(2));
    cyc();
    check("t3_in_ready_full", 128'(in_ready), 128'h0);
    check("t3_head",          128'(out_data), 128'h11);
    drive(1'b1, DW'(8'h33), CW'(3));
    cyc();
    check("t3_in_ready_hold", 128'(in_ready), 128'h0);
    check("t3_head_hold",     128'(out_data), 128'h11);
    check("t3_ctrl_hold",     128'(out_ctrl), 128'h1);
    out_ready = 1'b1;
    cyc(); cyc();
    drive(1'b0, '0, '0);
    cyc(); cyc();
    check("t3_drained", 128'(sb_q.size()), 128'h0);

    // 4: flush while FULL with a competing input
    out_ready = 1'b0;
    drive(1'b1, DW'(8'h55), CW'(5));
    cyc();
    drive(1'b1, DW'(8'h66), CW'(6));
    cyc();
    flush = 1'b1;
    drive(1'b1, DW'(8'h44), CW'(4));
    cyc();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    check("t4_out_valid", 128'(out_valid), 128'h0);
    check("t4_out_ctrl",  128'(out_ctrl),  128'h0);
    check("t4_in_ready",  128'(in_ready),  128'h1);
    out_ready = 1'b1;
    cyc(); cyc(); cyc();

    // 4b: flush coinciding with a consume; the consumed head still counts
    drive(1'b1, DW'(8'h77), CW'(7));
    cyc();
    flush = 1'b1;
    drive(1'b1, DW'(8'h88), CW'(8));
    cyc();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    check("t4b_out_valid", 128'(out_valid), 128'h0);
    cyc(); cyc();
    check("t4b_drained", 128'(sb_q.size()), 128'h0);

    // 5: asynchronous reset between edges
    drive(1'b1, DW'(8'h90), CW'(9));
    cyc();
    drive(1'b1, DW'(8'h91), CW'(9));
    cyc();
    #2;
    nRST = 1'b0;
    #1;
    check("t5_out_valid", 128'(out_valid), 128'h0);
    check("t5_in_ready",  128'(in_ready),  128'h1);
    check("t5_out_ctrl",  128'(out_ctrl),  128'h0);
    drive(1'b0, '0, '0);
    cyc(); cyc();
    nRST = 1'b1;
    cyc();

`ifdef PIPE_PERF_EN
    // 6: counters (3-bit instance so saturation is reachable)
    nRST = 1'b0; out_ready = 1'b0;
    cyc();
    nRST = 1'b1;
    cyc();
    drive(1'b1, DW'(8'hAB), CW'(8'hA));
    cyc();
    drive(1'b0, '0, '0);
    cyc(); cyc(); cyc();
    out_ready = 1'b1;
    cyc();
    check("t6_stall_cnt",  128'(stall_cnt),  128'h3);
    check("t6_bubble_cnt", 128'(bubble_cnt), 128'h2);
    for (int i = 0; i < 10; i++) cyc();
    check("t6_bubble_sat", 128'(bubble_cnt), 128'h7);
    check("t6_stall_keep", 128'(stall_cnt),  128'h3);
`endif

    check("final_drained", 128'(sb_q.size()), 128'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
